// File: rtl/decode_issue_stage_if.sv
// Signal bundle around the decode/issue stage: IF/ID handshake, ID/EX register,
// WB busy-clear and ROB commit/flush feedback.
interface decode_issue_stage_if #(
    parameter int XLEN      = 32,
    parameter int REG_W     = 5,
    parameter int PAYLOAD_W = 16,
    parameter int ROB_IDX_W = 4
);
    logic                 in_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      in_PC;
    logic [REG_W-1:0]     in_rs1;
    logic [REG_W-1:0]     in_rs2;
    logic [REG_W-1:0]     in_rd;
    logic                 in_uses_rs1;
    logic                 in_uses_rs2;
    logic                 in_writes_rd;
    logic                 in_long_latency;
    logic                 in_needs_rob;
    logic [PAYLOAD_W-1:0] in_payload;

    logic                 out_valid;
    logic                 in_ex_ready;
    logic [XLEN-1:0]      out_PC;
    logic [REG_W-1:0]     out_rd;
    logic [REG_W-1:0]     out_rs1;
    logic [REG_W-1:0]     out_rs2;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_allocate;
    logic [ROB_IDX_W-1:0] out_rob_idx;

    logic                 in_write_enable;
    logic [REG_W-1:0]     in_write_reg;
    logic                 in_commit;
    logic                 in_flush;
    logic                 out_rob_full;

    modport slave (
        input  in_valid, in_PC, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
               in_writes_rd, in_long_latency, in_needs_rob, in_payload, in_ex_ready,
               in_write_enable, in_write_reg, in_commit, in_flush,
        output out_ready, out_valid, out_PC, out_rd, out_rs1, out_rs2, out_payload,
               out_allocate, out_rob_idx, out_rob_full
    );

    modport master (
        output in_valid, in_PC, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
               in_writes_rd, in_long_latency, in_needs_rob, in_payload, in_ex_ready,
               in_write_enable, in_write_reg, in_commit, in_flush,
        input  out_ready, out_valid, out_PC, out_rd, out_rs1, out_rs2, out_payload,
               out_allocate, out_rob_idx, out_rob_full
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: busy-register scoreboard, ROB tail allocation and the
// ID/EX pipeline register behind a valid/ready handshake on both sides.
module decode_issue_stage #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int ROB_DEPTH = 16,
    parameter int ROB_IDX_W = $clog2(ROB_DEPTH),
    parameter int PAYLOAD_W = 16,
    parameter int REG_W     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    decode_issue_stage_if.slave  bus
);
    localparam int                CNT_W       = ROB_IDX_W + 1;
    localparam logic [CNT_W-1:0]  ROB_DEPTH_C = CNT_W'(ROB_DEPTH);
    localparam logic [REG_W-1:0]  REG_ZERO    = {REG_W{1'b0}};

    logic [NREGS-1:0]     busy_r;
    logic [NREGS-1:0]     busy_nxt_s;
    logic [ROB_IDX_W-1:0] rob_tail_r;
    logic [ROB_IDX_W-1:0] rob_tail_nxt_s;
    logic [CNT_W-1:0]     rob_count_r;
    logic [CNT_W-1:0]     rob_count_nxt_s;
    logic                 rob_full_r;

    logic                 hazard_s;
    logic                 rob_block_s;
    logic                 slot_free_s;
    logic                 ready_s;
    logic                 fire_s;
    logic                 alloc_s;
    logic                 retire_s;
    logic                 set_busy_s;
    logic                 clr_busy_s;

    logic                 valid_r;
    logic                 allocate_r;
    logic [ROB_IDX_W-1:0] rob_idx_r;
    logic [XLEN-1:0]      pc_r;
    logic [REG_W-1:0]     rd_r;
    logic [REG_W-1:0]     rs1_r;
    logic [REG_W-1:0]     rs2_r;
    logic [PAYLOAD_W-1:0] payload_r;

    // Issue decision: only the registered busy bits are consulted, no WB bypass.
    always_comb begin
        hazard_s    = (bus.in_uses_rs1  & busy_r[bus.in_rs1]) |
                      (bus.in_uses_rs2  & busy_r[bus.in_rs2]) |
                      (bus.in_writes_rd & busy_r[bus.in_rd]);
        rob_block_s = bus.in_needs_rob & rob_full_r;
        slot_free_s = ~valid_r | bus.in_ex_ready;
        ready_s     = ~hazard_s & ~rob_block_s & slot_free_s & ~bus.in_flush;
        fire_s      = bus.in_valid & ready_s;
        alloc_s     = fire_s & bus.in_needs_rob;
        retire_s    = bus.in_commit & (rob_count_r != {CNT_W{1'b0}});
        set_busy_s  = fire_s & bus.in_writes_rd & bus.in_long_latency & (bus.in_rd != REG_ZERO);
        clr_busy_s  = bus.in_write_enable & (bus.in_write_reg != REG_ZERO);
    end

    // Next scoreboard and ROB bookkeeping; flush wins over everything, a new set wins over a WB clear.
    always_comb begin
        busy_nxt_s      = busy_r;
        rob_tail_nxt_s  = rob_tail_r;
        rob_count_nxt_s = rob_count_r;
        if (bus.in_flush) begin
            busy_nxt_s      = {NREGS{1'b0}};
            rob_count_nxt_s = {CNT_W{1'b0}};
        end else begin
            if (clr_busy_s) begin
                busy_nxt_s[bus.in_write_reg] = 1'b0;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
            if (set_busy_s) begin
                busy_nxt_s[bus.in_rd] = 1'b1;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
            if (alloc_s) begin
                rob_tail_nxt_s = rob_tail_r + ROB_IDX_W'(1);
            end else begin
                rob_tail_nxt_s = rob_tail_r;
            end
            case ({alloc_s, retire_s})
                2'b10:   rob_count_nxt_s = rob_count_r + CNT_W'(1);
                2'b01:   rob_count_nxt_s = rob_count_r - CNT_W'(1);
                default: rob_count_nxt_s = rob_count_r;
            endcase
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard, ROB pointer/count and registered full flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r      <= {NREGS{1'b0}};
            rob_tail_r  <= {ROB_IDX_W{1'b0}};
            rob_count_r <= {CNT_W{1'b0}};
            rob_full_r  <= 1'b0;
        end else begin
            busy_r      <= busy_nxt_s;
            rob_tail_r  <= rob_tail_nxt_s;
            rob_count_r <= rob_count_nxt_s;
            rob_full_r  <= (rob_count_nxt_s == ROB_DEPTH_C);
        end
    end

    // ID/EX register: loads on fire, drains when EX takes it, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r    <= 1'b0;
            allocate_r <= 1'b0;
            rob_idx_r  <= {ROB_IDX_W{1'b0}};
            pc_r       <= {XLEN{1'b0}};
            rd_r       <= {REG_W{1'b0}};
            rs1_r      <= {REG_W{1'b0}};
            rs2_r      <= {REG_W{1'b0}};
            payload_r  <= {PAYLOAD_W{1'b0}};
        end else if (bus.in_flush) begin
            valid_r    <= 1'b0;
        end else if (fire_s) begin
            valid_r    <= 1'b1;
            allocate_r <= bus.in_needs_rob;
            rob_idx_r  <= bus.in_needs_rob ? rob_tail_r : {ROB_IDX_W{1'b0}};
            pc_r       <= bus.in_PC;
            rd_r       <= bus.in_rd;
            rs1_r      <= bus.in_rs1;
            rs2_r      <= bus.in_rs2;
            payload_r  <= bus.in_payload;
        end else if (bus.in_ex_ready) begin
            valid_r    <= 1'b0;
        end else begin
            valid_r    <= valid_r;
        end
    end

    assign bus.out_ready    = ready_s;
    assign bus.out_valid    = valid_r;
    assign bus.out_allocate = allocate_r;
    assign bus.out_rob_idx  = rob_idx_r;
    assign bus.out_PC       = pc_r;
    assign bus.out_rd       = rd_r;
    assign bus.out_rs1      = rs1_r;
    assign bus.out_rs2      = rs2_r;
    assign bus.out_payload  = payload_r;
    assign bus.out_rob_full = rob_full_r;
endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Parametrised decode/issue stage for the in-order pipeline. It replaces enable/disable stall wiring with a valid/ready handshake on both sides and registers the ID/EX boundary inside the block. It tracks long-latency writers in a per-register busy scoreboard and allocates reorder-buffer (ROB) entries from an internal tail pointer with occupancy counting. Sits between the fetch pipeline register and the execute stage; field decoding stays in the existing decoder, which feeds this block.

## Interface
- XLEN, 32, data/PC width
- NREGS, 32, architectural register count; register 0 is never busy
- ROB_DEPTH, 16, ROB entries (power of two)
- ROB_IDX_W, $clog2(ROB_DEPTH), ROB index width
- PAYLOAD_W, 16, opaque control bundle (EX/MEM/WB control) passed through unmodified
- REG_W, $clog2(NREGS), register index width

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present from IF/ID
- out_ready  out  1  stage accepts the instruction this cycle
- in_PC  in  XLEN  instruction PC
- in_rs1, in_rs2, in_rd  in  REG_W each  register indices
- in_uses_rs1, in_uses_rs2  in  1 each  source operand actually read
- in_writes_rd  in  1  instruction writes rd
- in_long_latency  in  1  result not forwardable (load, multi-cycle op)
- in_needs_rob  in  1  instruction needs a ROB entry
- in_payload  in  PAYLOAD_W  control bundle
- out_valid  out  1  ID/EX register holds a valid instruction
- in_ex_ready  in  1  EX accepts the ID/EX register contents
- out_PC, out_rd, out_rs1, out_rs2, out_payload  out  (matching widths)  registered copies
- out_allocate  out  1  registered: instruction owns a ROB entry
- out_rob_idx  out  ROB_IDX_W  registered: allocated entry (0 when out_allocate=0)
- in_write_enable, in_write_reg  in  1 / REG_W  WB writeback; clears busy
- in_commit  in  1  ROB retired one entry
- in_flush  in  1  squash: taken branch or exception
- out_rob_full  out  1  count == ROB_DEPTH

## Operation
- State: busy[NREGS], rob_tail (ROB_IDX_W), rob_count (0..ROB_DEPTH, ROB_IDX_W+1 bits), ID/EX register.
- hazard = (in_uses_rs1 & busy[in_rs1]) | (in_uses_rs2 & busy[in_rs2]) | (in_writes_rd & busy[in_rd]). This covers RAW and WAW. Only registered busy is used; there is no same-cycle WB bypass.
- rob_block = in_needs_rob & out_rob_full.
- slot_free = !out_valid | in_ex_ready.
- out_ready = !hazard & !rob_block & slot_free & !in_flush. It is combinational and does not depend on in_valid.
- fire = in_valid & out_ready.
- On fire:
  - Load the ID/EX register and set out_valid=1.
  - If in_needs_rob: out_allocate=1, out_rob_idx=rob_tail, rob_tail+1 (wraps mod ROB_DEPTH), rob_count+1.
  - If in_writes_rd & in_long_latency & in_rd!=0: set busy[in_rd].
- No fire and in_ex_ready: clear out_valid. Other registered fields hold their values.
- WB: in_write_enable & in_write_reg!=0 clears busy[in_write_reg]. If it hits the same register being set this cycle, the set wins.
- Commit: rob_count-1. Commit when rob_count==0 is ignored. Allocate and commit in the same cycle leave the count unchanged.
- Flush (highest priority):
  - out_valid=0, all busy cleared, rob_count=0.
  - rob_tail holds its value.
  - No fire; commit ignored that cycle.
- busy[0] is always 0.

## Timing
- Reset values: out_valid=0, out_allocate=0, out_rob_idx=0, out_PC/rd/rs1/rs2/payload=0, busy all 0, rob_tail=0, rob_count=0, out_rob_full=0, out_ready evaluates to 1 when in_flush=0.
- Latency: an instruction accepted in cycle N appears on the out_* ports in cycle N+1.
- Back-to-back issue at one per cycle while in_ex_ready=1 and there is no hazard.
- A dependent consumer of a long-latency producer is accepted no earlier than the cycle after the WB cycle that clears busy.
- out_rob_full is registered-derived: asserted the cycle after the ROB_DEPTH-th outstanding allocation.
- Holding in_ex_ready=0 keeps the ID/EX contents stable; out_ready stays 0 while out_valid=1.
- Reset in mid-operation discards everything in the next cycle, identically to flush, and also zeroes rob_tail.

## Test plan
- Independent stream: 4 ALU instructions, in_ex_ready=1 -> out_valid high cycles 1–4, out_rob_idx 0,1,2,3, rob_count=4.
- Load-use: load x5 (long_latency) then add x6,x5,x1 -> out_ready=0 until the cycle after in_write_enable with reg 5; add issues one cycle after WB.
- ROB full: ROB_DEPTH=4, 5 needs_rob instructions, no commit -> 5th stalls with out_rob_full=1. Commit pulse -> 5th issues next cycle with out_rob_idx=0 (wrap).
- Backpressure: out_valid=1, in_ex_ready=0 for 3 cycles -> outputs stable, out_ready=0. Release -> next instruction loads the following cycle.
- Flush with busy x7 and rob_count=3 plus a simultaneous in_valid -> no fire, next cycle out_valid=0, busy[7]=0, rob_count=0, rob_tail unchanged.
- x0 and collision: long-latency write to x0 -> busy[0] stays 0. Same-cycle WB clear and new set of x9 -> busy[9]=1.
